switch_debouncer: RTL and testbench
===================================

SWITCH_DEBOUNCER -- requirements
Module: switch_debouncer

Interface
REQ-001 The block SHALL use reset, synchronous, active-high, and clock clk.
REQ-002 Parameter WIDTH, default 8: number of switch inputs, matching the GPIO switch port width.
REQ-003 Parameter CNT_MAX, default 50000: clk cycles an input must hold a new level before acceptance (1 ms at 50 MHz); legal range 2..2^CNT_W-1.
REQ-004 Parameter CNT_W, default 16: width of each per-bit stability counter.
REQ-005 clk  input  1  system clock.
REQ-006 reset  input  1  synchronous active-high reset.
REQ-007 sw_raw  input  WIDTH  asynchronous board switch pins, may bounce.
REQ-008 irq_clear  input  1  one-cycle strobe from software clearing irq_pending.
REQ-009 sw_db  output  WIDTH  registered debounced switch levels; drives GPIO gpio_port_in.
REQ-010 sw_rise  output  WIDTH  per-bit one-cycle pulse, sw_db bit went 0->1.
REQ-011 sw_fall  output  WIDTH  per-bit one-cycle pulse, sw_db bit went 1->0.
REQ-012 sw_changed  output  1  one-cycle pulse, OR of all sw_rise/sw_fall bits.
REQ-013 irq_pending  output  1  sticky flag, set by any debounced change.

Function
REQ-014 sw_raw SHALL pass through a 2-flop synchronizer (sync1, sync2) per bit before any other use; no logic between the flops.
REQ-015 Per bit i, each clk edge: if sync2[i]==sw_db[i], cnt[i]<=0.
REQ-016 Else if cnt[i]==CNT_MAX-1: sw_db[i]<=sync2[i], cnt[i]<=0.
REQ-017 Else cnt[i]<=cnt[i]+1; counters SHALL never wrap past CNT_MAX-1.
REQ-018 Latency: a clean level change on sw_raw[i] SHALL appear on sw_db[i] at exactly the (CNT_MAX+2)th clk edge, counting the first edge sampling the new level as edge 1.
REQ-019 Any return of sync2[i] to sw_db[i] before acceptance (bounce) SHALL clear cnt[i]; a new level is accepted only after CNT_MAX consecutive cycles of disagreement.
REQ-020 Bits SHALL be debounced independently; simultaneous changes on several bits SHALL each be accepted on their own count.
REQ-021 sw_rise[i]/sw_fall[i] SHALL be registered and asserted for exactly the one cycle in which sw_db[i] first shows the new value; never both set for the same bit.
REQ-022 sw_changed SHALL be asserted in the same cycle as any sw_rise/sw_fall bit, one cycle only.
REQ-023 irq_pending SHALL set on the edge following sw_changed and hold until the edge following an irq_clear strobe.
REQ-024 Simultaneous sw_changed and irq_clear: set SHALL win, irq_pending stays 1.
REQ-025 irq_clear with irq_pending=0 and no change: no effect.
REQ-026 Outputs SHALL be glitch-free registered values; no combinational path from sw_raw to any output.

Reset
REQ-027 On reset: sync1, sync2, sw_db, all cnt[i], sw_rise, sw_fall, sw_changed, irq_pending SHALL all be 0 on the next edge.
REQ-028 Reset mid-count SHALL discard the partial count; switches held high through reset SHALL be accepted CNT_MAX+2 edges after reset deasserts, with sw_rise pulse and irq_pending set.
REQ-029 reset SHALL take priority over irq_clear and all counting.

Verification (CNT_MAX=4, WIDTH=8)
REQ-030 Clean press: sw_raw 0x00->0x01 held -> sw_db=0x01 at edge 6, sw_rise=0x01 and sw_changed=1 for that cycle only, irq_pending=1 next edge.
REQ-031 Bounce: sw_raw bit0 toggles 1,0,1,0 each 2 cycles then holds 1 -> no sw_db change during bounce; sw_db[0]=1 exactly 6 edges after last 0->1.
REQ-032 Release and multi-bit: sw_db=0x81, sw_raw->0x00 -> sw_db=0x00 after 6 edges, sw_fall=0x81 one cycle, sw_changed single pulse.
REQ-033 IRQ race: irq_clear asserted in same cycle as sw_changed -> irq_pending remains 1; lone irq_clear later -> irq_pending=0 next edge.
REQ-034 Reset mid-count: sw_raw=0xFF, reset at edge 3 for one cycle -> all outputs 0; sw_db=0xFF 6 edges after reset deasserts, sw_rise=0xFF.
REQ-035 Glitch: single-cycle 1 pulse on sw_raw bit3 -> sw_db, pulses, irq_pending unchanged.

Source files
------------

// File: rtl/switch_debouncer.sv
// Per-bit switch debouncer: 2-flop synchronizer, stability counter per bit,
// registered rise/fall/changed pulses and a sticky interrupt flag.
module switch_debouncer #(
    parameter int WIDTH   = 8,
    parameter int CNT_MAX = 50000,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] sw_raw,
    input  logic             irq_clear,
    output logic [WIDTH-1:0] sw_db,
    output logic [WIDTH-1:0] sw_rise,
    output logic [WIDTH-1:0] sw_fall,
    output logic             sw_changed,
    output logic             irq_pending
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_MAX - 1);

    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;
    logic [CNT_W-1:0] cnt [WIDTH];
    logic [WIDTH-1:0] differ;
    logic [WIDTH-1:0] accept;

    // A bit is accepted on the edge where its counter has already seen
    // CNT_MAX-1 disagreeing cycles and the current cycle still disagrees.
    always_comb begin
        differ = sync2 ^ sw_db;
        accept = '0;
        for (int i = 0; i < WIDTH; i++) begin
            accept[i] = differ[i] && (cnt[i] == CNT_LAST);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1       <= '0;
            sync2       <= '0;
            sw_db       <= '0;
            sw_rise     <= '0;
            sw_fall     <= '0;
            sw_changed  <= 1'b0;
            irq_pending <= 1'b0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            sync1 <= sw_raw;
            sync2 <= sync1;
            for (int i = 0; i < WIDTH; i++) begin
                if (!differ[i] || accept[i]) begin
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CNT_W'(1);
                end
            end
            sw_db      <= sw_db ^ accept;
            sw_rise    <= accept & sync2;
            sw_fall    <= accept & ~sync2;
            sw_changed <= |accept;
            // A new change outranks a clear arriving in the same cycle.
            irq_pending <= sw_changed | (irq_pending & ~irq_clear);
        end
    end

endmodule

// File: tb/tb_switch_debouncer.sv
// Bench for switch_debouncer: directed scenarios plus random switch activity,
// compared every cycle against a sliding-window reference model.
module tb_switch_debouncer;

    localparam int W  = 8;
    localparam int CM = 4;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [W-1:0] sw_raw = '0;
    logic         irq_clear = 1'b0;
    logic [W-1:0] sw_db;
    logic [W-1:0] sw_rise;
    logic [W-1:0] sw_fall;
    logic         sw_changed;
    logic         irq_pending;

    always #5 clk = ~clk;

    switch_debouncer #(
        .WIDTH  (W),
        .CNT_MAX(CM),
        .CNT_W  (16)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .sw_raw     (sw_raw),
        .irq_clear  (irq_clear),
        .sw_db      (sw_db),
        .sw_rise    (sw_rise),
        .sw_fall    (sw_fall),
        .sw_changed (sw_changed),
        .irq_pending(irq_pending)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: the raw level reaches the debouncer two edges late;
    // a bit flips when the last CM delayed samples all disagree with it.
    logic [W-1:0] m_s1 = '0, m_s2 = '0;
    logic [W-1:0] e_db = '0, e_rise = '0, e_fall = '0;
    logic         e_chg = 1'b0, e_irq = 1'b0;
    logic [W-1:0] hist [CM];
    int           hist_n = 0;

    task automatic model_step(input logic [W-1:0] r, input logic clr, input logic rst);
        logic [W-1:0] acc;
        logic         all_diff;
        if (rst) begin
            m_s1 = '0; m_s2 = '0; e_db = '0; e_rise = '0; e_fall = '0;
            e_chg = 1'b0; e_irq = 1'b0; hist_n = 0;
        end else begin
            e_irq = e_chg | (e_irq & ~clr);
            for (int k = CM - 1; k > 0; k--) hist[k] = hist[k-1];
            hist[0] = m_s2;
            if (hist_n < CM) hist_n++;
            acc = '0;
            if (hist_n == CM) begin
                for (int i = 0; i < W; i++) begin
                    all_diff = 1'b1;
                    for (int k = 0; k < CM; k++) if (hist[k][i] == e_db[i]) all_diff = 1'b0;
                    acc[i] = all_diff;
                end
            end
            e_rise = acc & m_s2;
            e_fall = acc & ~m_s2;
            e_chg  = |acc;
            e_db   = e_db ^ acc;
            m_s2 = m_s1;
            m_s1 = r;
        end
    endtask

    // Drive inputs away from the active edge, advance one clock, compare at negedge.
    task automatic step(input logic [W-1:0] r, input logic clr, input logic rst);
        sw_raw = r; irq_clear = clr; reset = rst;
        model_step(r, clr, rst);
        @(posedge clk);
        @(negedge clk);
        check("model_db",   32'(sw_db),       32'(e_db));
        check("model_rise", 32'(sw_rise),     32'(e_rise));
        check("model_fall", 32'(sw_fall),     32'(e_fall));
        check("model_chg",  32'(sw_changed),  32'(e_chg));
        check("model_irq",  32'(irq_pending), 32'(e_irq));
    endtask

    task automatic hold(input logic [W-1:0] r, input int n);
        for (int k = 0; k < n; k++) step(r, 1'b0, 1'b0);
    endtask

    initial begin
        logic [W-1:0] cur;
        int           len;

        // Reset
        step(8'h00, 1'b0, 1'b1);
        step(8'h00, 1'b0, 1'b1);
        check("rst_db",   32'(sw_db),       32'h0);
        check("rst_rise", 32'(sw_rise),     32'h0);
        check("rst_irq",  32'(irq_pending), 32'h0);
        hold(8'h00, 3);

        // Clean press: accepted on edge CM+2
        for (int e = 1; e <= 6; e++) begin
            step(8'h01, 1'b0, 1'b0);
            if (e == 5) check("press_db_early", 32'(sw_db), 32'h00);
        end
        check("press_db",   32'(sw_db),      32'h01);
        check("press_rise", 32'(sw_rise),    32'h01);
        check("press_chg",  32'(sw_changed), 32'h1);
        step(8'h01, 1'b0, 1'b0);
        check("press_rise_off", 32'(sw_rise),     32'h00);
        check("press_chg_off",  32'(sw_changed),  32'h0);
        check("press_irq",      32'(irq_pending), 32'h1);

        // Bounce
        hold(8'h00, 8);
        check("bounce_pre", 32'(sw_db), 32'h00);
        for (int rep = 0; rep < 2; rep++) begin
            hold(8'h01, 2);
            check("bounce_hi", 32'(sw_db), 32'h00);
            hold(8'h00, 2);
            check("bounce_lo", 32'(sw_db), 32'h00);
        end
        for (int e = 1; e <= 6; e++) begin
            step(8'h01, 1'b0, 1'b0);
            if (e == 5) check("bounce_db_early", 32'(sw_db), 32'h00);
        end
        check("bounce_db", 32'(sw_db), 32'h01);

        // Release, two bits at once
        hold(8'h81, 8);
        check("multi_set", 32'(sw_db), 32'h81);
        for (int e = 1; e <= 6; e++) begin
            step(8'h00, 1'b0, 1'b0);
            if (e == 5) check("rel_db_early", 32'(sw_db), 32'h81);
        end
        check("rel_db",   32'(sw_db),      32'h00);
        check("rel_fall", 32'(sw_fall),    32'h81);
        check("rel_rise", 32'(sw_rise),    32'h00);
        check("rel_chg",  32'(sw_changed), 32'h1);
        step(8'h00, 1'b0, 1'b0);
        check("rel_fall_off", 32'(sw_fall),    32'h00);
        check("rel_chg_off",  32'(sw_changed), 32'h0);

        // IRQ clear, idle clear, and set-vs-clear race
        step(8'h00, 1'b1, 1'b0);
        check("irq_clr", 32'(irq_pending), 32'h0);
        step(8'h00, 1'b1, 1'b0);
        check("irq_idle_clr", 32'(irq_pending), 32'h0);
        hold(8'h02, 6);
        check("race_chg", 32'(sw_changed), 32'h1);
        step(8'h02, 1'b1, 1'b0);
        check("race_irq", 32'(irq_pending), 32'h1);
        step(8'h02, 1'b0, 1'b0);
        check("race_irq_hold", 32'(irq_pending), 32'h1);
        step(8'h02, 1'b1, 1'b0);
        check("late_clr", 32'(irq_pending), 32'h0);

        // Reset mid-count
        hold(8'hFF, 2);
        step(8'hFF, 1'b0, 1'b1);
        check("rstmid_db",   32'(sw_db),       32'h00);
        check("rstmid_chg",  32'(sw_changed),  32'h0);
        check("rstmid_irq",  32'(irq_pending), 32'h0);
        for (int e = 1; e <= 6; e++) begin
            step(8'hFF, 1'b0, 1'b0);
            if (e == 5) check("rstmid_db_early", 32'(sw_db), 32'h00);
        end
        check("rstmid_db_acc", 32'(sw_db),   32'hFF);
        check("rstmid_rise",   32'(sw_rise), 32'hFF);
        step(8'hFF, 1'b0, 1'b0);
        check("rstmid_irq_set", 32'(irq_pending), 32'h1);

        // Single-cycle glitch on bit 3
        hold(8'hF7, 8);
        step(8'hF7, 1'b1, 1'b0);
        check("glitch_pre", 32'(sw_db), 32'hF7);
        step(8'hFF, 1'b0, 1'b0);
        for (int e = 0; e < 10; e++) begin
            step(8'hF7, 1'b0, 1'b0);
            check("glitch_db",  32'(sw_db),      32'hF7);
            check("glitch_chg", 32'(sw_changed), 32'h0);
        end
        check("glitch_irq", 32'(irq_pending), 32'h0);

        // Random activity with bounces, clears and occasional resets
        cur = 8'($urandom_range(0, 255));
        for (int t = 0; t < 60; t++) begin
            if ($urandom_range(0, 1) == 0) cur = cur ^ (8'h01 << $urandom_range(0, 7));
            else cur = cur ^ 8'($urandom_range(0, 255));
            len = $urandom_range(1, 10);
            for (int k = 0; k < len; k++) begin
                step(cur, $urandom_range(0, 7) == 0, $urandom_range(0, 149) == 0);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
